// File: rtl/defs_pkg.sv
// Shared types for the CPU control path: opcodes, FSM states, ALU ops, flag and control bundles.
// Mux-select encodings live here so the datapath and the control unit agree on them.
package defs_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_ADDI = 4'h5,
        OP_CMP  = 4'h6,
        OP_LDI  = 4'h7,
        OP_LD   = 4'h8,
        OP_ST   = 4'h9,
        OP_JMP  = 4'hA,
        OP_BZ   = 4'hB,
        OP_BNZ  = 4'hC,
        OP_BN   = 4'hD,
        OP_JR   = 4'hE,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [3:0] {
        FETCH_A = 4'd0,
        FETCH_B = 4'd1,
        DECODE  = 4'd2,
        EXEC    = 4'd3,
        WB      = 4'd4,
        MEM_RD  = 4'd5,
        MEM_LD  = 4'd6,
        MEM_WB  = 4'd7,
        ST_AB   = 4'd8,
        ST_WR   = 4'd9,
        HALT    = 4'd10
    } cu_state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_t;

    localparam logic       PC_SEL_AB         = 1'b0;
    localparam logic       PC_SEL_ADDER      = 1'b1;
    localparam logic [1:0] ADDER_SEL_SIMM12  = 2'd0;
    localparam logic [1:0] ADDER_SEL_SIMM8   = 2'd1;
    localparam logic [1:0] ADDER_SEL_INC2    = 2'd2;
    localparam logic       REG2_SEL_RD       = 1'b0;
    localparam logic       REG2_SEL_RB       = 1'b1;
    localparam logic [1:0] REGW_SEL_ACC      = 2'd0;
    localparam logic [1:0] REGW_SEL_MDR      = 2'd1;
    localparam logic [1:0] REGW_SEL_IMM      = 2'd2;
    localparam logic       ALU_SEL_SIMM4     = 1'b0;
    localparam logic       ALU_SEL_A         = 1'b1;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

    typedef struct packed {
        logic       ir_load;
        logic       ab_load;
        logic       reg2_sel;
        logic       pc_write;
        logic       pc_sel;
        logic [1:0] adder_sel;
        alu_op_t    alu_op;
        logic       alu_sel;
        logic       acc_load;
        logic       flag_load;
        logic       rf_write;
        logic [1:0] regw_sel;
        logic       mar_load;
        logic       mem_read;
        logic       mdr_load;
        logic       mem_write;
    } ctrl_sig_t;

    // Opcodes whose result goes through ACC and back to the register file.
    function automatic logic is_acc_op(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR) || (op == OP_ADDI);
    endfunction

    function automatic alu_op_t alu_op_of(input opcode_t op);
        alu_op_t res;
        res = ALU_ADD;
        case (op)
            OP_SUB:  res = ALU_SUB;
            OP_AND:  res = ALU_AND;
            OP_OR:   res = ALU_OR;
            OP_XOR:  res = ALU_XOR;
            OP_CMP:  res = ALU_SUB;
            default: res = ALU_ADD;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cu_branch_eval.sv
// Branch condition evaluation for the control unit; JMP counts as always taken.
module cu_branch_eval
    import defs_pkg::*;
(
    input  opcode_t    opcode,
    input  alu_flags_t flags,
    output logic       take
);

    logic unused_flags;
    assign unused_flags = flags.c ^ flags.v;

    always_comb begin
        take = 1'b0;
        case (opcode)
            OP_JMP:  take = 1'b1;
            OP_BZ:   take = flags.z;
            OP_BNZ:  take = ~flags.z;
            OP_BN:   take = flags.n;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control FSM: fetch, decode, execute, memory and writeback sequencing.
// Optional retired-instruction counter enabled by defining CU_RETIRE_CNT_EN.
//
// state   | meaning
// FETCH_A | wait for synchronous ROM read
// FETCH_B | load IR
// DECODE  | load A/B, PC += 2
// EXEC    | opcode-dependent execute
// WB      | write ACC to register file
// MEM_RD  | data memory read issued
// MEM_LD  | capture read data into MDR
// MEM_WB  | write MDR to register file
// ST_AB   | reload B with rd for store data
// ST_WR   | data memory write
// HALT    | stopped until reset
module control_unit
    import defs_pkg::*;
#(
    parameter int INSTR_WIDTH = 16,
    parameter int OPC_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INSTR_WIDTH-1:0] instruct,
    input  alu_flags_t             flags,
    output ctrl_sig_t              sigs,
    output logic                   halted,
    output cu_state_t              state_dbg
`ifdef CU_RETIRE_CNT_EN
    ,
    output logic [31:0]            retired
`endif
);

    cu_state_t state, state_next;
    opcode_t   opcode;
    logic      take;

    assign opcode    = opcode_t'(instruct[OPC_WIDTH-1:0]);
    assign state_dbg = state;

    logic unused_operands;
    assign unused_operands = ^instruct[INSTR_WIDTH-1:OPC_WIDTH];

    cu_branch_eval u_branch_eval (
        .opcode (opcode),
        .flags  (flags),
        .take   (take)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        sigs       = '0;
        halted     = 1'b0;
        state_next = state;
        case (state)
            FETCH_A: state_next = FETCH_B;
            FETCH_B: begin
                sigs.ir_load = 1'b1;
                state_next   = DECODE;
            end
            DECODE: begin
                sigs.ab_load   = 1'b1;
                sigs.reg2_sel  = (opcode == OP_ADDI) ? REG2_SEL_RD : REG2_SEL_RB;
                // PC already points at the next instruction before any branch offset is applied.
                sigs.pc_write  = 1'b1;
                sigs.pc_sel    = PC_SEL_ADDER;
                sigs.adder_sel = ADDER_SEL_INC2;
                state_next     = EXEC;
            end
            EXEC: begin
                state_next = FETCH_A;
                if (is_acc_op(opcode)) begin
                    sigs.alu_op    = alu_op_of(opcode);
                    sigs.alu_sel   = (opcode == OP_ADDI) ? ALU_SEL_SIMM4 : ALU_SEL_A;
                    sigs.acc_load  = 1'b1;
                    sigs.flag_load = 1'b1;
                    state_next     = WB;
                end else begin
                    case (opcode)
                        OP_CMP: begin
                            sigs.alu_op    = ALU_SUB;
                            sigs.flag_load = 1'b1;
                        end
                        OP_LDI: begin
                            sigs.rf_write = 1'b1;
                            sigs.regw_sel = REGW_SEL_IMM;
                        end
                        OP_LD: begin
                            sigs.mar_load = 1'b1;
                            state_next    = MEM_RD;
                        end
                        OP_ST: begin
                            sigs.mar_load = 1'b1;
                            state_next    = ST_AB;
                        end
                        OP_JMP, OP_BZ, OP_BNZ, OP_BN: begin
                            if (take) begin
                                sigs.pc_write  = 1'b1;
                                sigs.pc_sel    = PC_SEL_ADDER;
                                sigs.adder_sel = (opcode == OP_JMP) ? ADDER_SEL_SIMM12
                                                                    : ADDER_SEL_SIMM8;
                            end
                        end
                        OP_JR: begin
                            sigs.pc_write = 1'b1;
                            sigs.pc_sel   = PC_SEL_AB;
                        end
                        OP_HALT: state_next = HALT;
                        default: state_next = FETCH_A;
                    endcase
                end
            end
            WB: begin
                sigs.rf_write = 1'b1;
                sigs.regw_sel = REGW_SEL_ACC;
                state_next    = FETCH_A;
            end
            MEM_RD: begin
                sigs.mem_read = 1'b1;
                state_next    = MEM_LD;
            end
            MEM_LD: begin
                sigs.mem_read = 1'b1;
                sigs.mdr_load = 1'b1;
                state_next    = MEM_WB;
            end
            MEM_WB: begin
                sigs.rf_write = 1'b1;
                sigs.regw_sel = REGW_SEL_MDR;
                state_next    = FETCH_A;
            end
            ST_AB: begin
                sigs.ab_load  = 1'b1;
                sigs.reg2_sel = REG2_SEL_RD;
                state_next    = ST_WR;
            end
            ST_WR: begin
                sigs.mem_write = 1'b1;
                state_next     = FETCH_A;
            end
            HALT: begin
                halted     = 1'b1;
                state_next = HALT;
            end
            default: state_next = FETCH_A;
        endcase
    end

`ifdef CU_RETIRE_CNT_EN
    // FETCH_A never loops on itself, so entering it marks the end of one instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired <= '0;
        end else if (state_next == FETCH_A && state != FETCH_A) begin
            retired <= retired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected per-cycle state/strobes are queued per instruction
// and popped one per cycle on the falling edge.
module tb_control_unit;
    import defs_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [15:0] instruct;
    alu_flags_t flags;
    ctrl_sig_t  sigs;
    logic       halted;
    cu_state_t  state_dbg;
`ifdef CU_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    always #5 clk = ~clk;

    control_unit #(.INSTR_WIDTH(16), .OPC_WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .instruct  (instruct),
        .flags     (flags),
        .sigs      (sigs),
        .halted    (halted),
        .state_dbg (state_dbg)
`ifdef CU_RETIRE_CNT_EN
        ,
        .retired   (retired)
`endif
    );

    typedef struct {
        cu_state_t st;
        ctrl_sig_t s;
        logic      h;
    } step_t;

    step_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input cu_state_t st, input ctrl_sig_t s, input logic h = 1'b0);
        step_t e;
        e.st = st;
        e.s  = s;
        e.h  = h;
        sb.push_back(e);
    endtask

    task automatic push_front_end(input logic reg2);
        ctrl_sig_t s;
        push(FETCH_A, '0);
        s = '0;
        s.ir_load = 1'b1;
        push(FETCH_B, s);
        s = '0;
        s.ab_load   = 1'b1;
        s.reg2_sel  = reg2;
        s.pc_write  = 1'b1;
        s.pc_sel    = 1'b1;
        s.adder_sel = 2'd2;
        push(DECODE, s);
    endtask

    // Called at a falling edge with the DUT in the first queued state.
    task automatic drain(input string name);
        step_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({name, ".state"},  32'(state_dbg), 32'(e.st));
            check({name, ".sigs"},   32'(sigs),      32'(e.s));
            check({name, ".halted"}, 32'(halted),    32'(e.h));
            @(negedge clk);
        end
    endtask

    task automatic run_acc(input logic [15:0] ir, input alu_op_t op, input logic imm,
                           input string name);
        ctrl_sig_t s;
        instruct = ir;
        push_front_end(imm ? 1'b0 : 1'b1);
        s = '0;
        s.alu_op    = op;
        s.alu_sel   = imm ? 1'b0 : 1'b1;
        s.acc_load  = 1'b1;
        s.flag_load = 1'b1;
        push(EXEC, s);
        s = '0;
        s.rf_write = 1'b1;
        s.regw_sel = 2'd0;
        push(WB, s);
        drain(name);
    endtask

    task automatic run_branch(input logic [15:0] ir, input logic z, input logic n,
                              input logic taken, input logic [1:0] asel, input string name);
        ctrl_sig_t s;
        instruct = ir;
        flags    = '0;
        flags.z  = z;
        flags.n  = n;
        push_front_end(1'b1);
        s = '0;
        if (taken) begin
            s.pc_write  = 1'b1;
            s.pc_sel    = 1'b1;
            s.adder_sel = asel;
        end
        push(EXEC, s);
        drain(name);
        flags = '0;
    endtask

    task automatic run_exec_only(input logic [15:0] ir, input ctrl_sig_t s, input string name);
        instruct = ir;
        push_front_end(1'b1);
        push(EXEC, s);
        drain(name);
    endtask

    task automatic run_ld(input logic [15:0] ir);
        ctrl_sig_t s;
        instruct = ir;
        push_front_end(1'b1);
        s = '0; s.mar_load = 1'b1;                       push(EXEC, s);
        s = '0; s.mem_read = 1'b1;                       push(MEM_RD, s);
        s = '0; s.mem_read = 1'b1; s.mdr_load = 1'b1;    push(MEM_LD, s);
        s = '0; s.rf_write = 1'b1; s.regw_sel = 2'd1;    push(MEM_WB, s);
        drain("ld");
    endtask

    task automatic push_st_to_ab(input logic [15:0] ir);
        ctrl_sig_t s;
        instruct = ir;
        push_front_end(1'b1);
        s = '0; s.mar_load = 1'b1;                       push(EXEC, s);
        s = '0; s.ab_load = 1'b1; s.reg2_sel = 1'b0;     push(ST_AB, s);
    endtask

    task automatic measure(input logic [15:0] ir, input int exp, input string name);
        int n;
        instruct = ir;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (state_dbg != FETCH_A && n < 20);
        check(name, 32'(n), 32'(exp));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        ctrl_sig_t s;
        reset    = 1'b1;
        instruct = 16'h0000;
        flags    = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst.state",  32'(state_dbg), 32'(FETCH_A));
        check("rst.sigs",   32'(sigs),      32'h0);
        check("rst.halted", 32'(halted),    32'h0);
        reset = 1'b0;

        run_acc(16'h3210, ALU_ADD, 1'b0, "add");
        run_ld(16'h0128);
        push_st_to_ab(16'h0129);
        s = '0; s.mem_write = 1'b1; push(ST_WR, s);
        drain("st");

        run_branch(16'hFC0B, 1'b1, 1'b0, 1'b1, 2'd1, "bz_taken");
        run_branch(16'hFC0B, 1'b0, 1'b0, 1'b0, 2'd1, "bz_not");
        run_branch(16'h040C, 1'b0, 1'b0, 1'b1, 2'd1, "bnz_taken");
        run_branch(16'h000D, 1'b0, 1'b1, 1'b1, 2'd1, "bn_taken");
        run_branch(16'h000D, 1'b1, 1'b0, 1'b0, 2'd1, "bn_not");
        run_branch(16'h010A, 1'b0, 1'b0, 1'b1, 2'd0, "jmp");

        run_acc(16'h3015, ALU_ADD, 1'b1, "addi");
        run_acc(16'h3211, ALU_SUB, 1'b0, "sub");
        run_acc(16'h3212, ALU_AND, 1'b0, "and");
        run_acc(16'h3213, ALU_OR,  1'b0, "or");
        run_acc(16'h3214, ALU_XOR, 1'b0, "xor");

        s = '0; s.alu_op = ALU_SUB; s.flag_load = 1'b1;
        run_exec_only(16'h0126, s, "cmp");
        s = '0; s.rf_write = 1'b1; s.regw_sel = 2'd2;
        run_exec_only(16'h5A17, s, "ldi");
        s = '0; s.pc_write = 1'b1; s.pc_sel = 1'b0;
        run_exec_only(16'h120E, s, "jr");

        measure(16'h3210, 5, "lat.add");
        measure(16'h0128, 7, "lat.ld");
        measure(16'h0129, 6, "lat.st");
        measure(16'h0126, 4, "lat.cmp");

        // Reset landing in ST_WR must kill the write in the same cycle.
        push_st_to_ab(16'h0129);
        drain("st_pre");
        check("st_wr.state", 32'(state_dbg),      32'(ST_WR));
        check("st_wr.mem_write", 32'(sigs.mem_write), 32'h1);
        reset = 1'b1;
        #1;
        check("st_rst.state",     32'(state_dbg),      32'(FETCH_A));
        check("st_rst.sigs",      32'(sigs),           32'h0);
        check("st_rst.mem_write", 32'(sigs.mem_write), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        check("st_rel.state",  32'(state_dbg), 32'(FETCH_A));
        check("st_rel.halted", 32'(halted),    32'h0);

        pulse_reset();
`ifdef CU_RETIRE_CNT_EN
        check("ret.reset", retired, 32'd0);
`endif
        run_acc(16'h3210, ALU_ADD, 1'b0, "ret_add");
        s = '0; s.alu_op = ALU_SUB; s.flag_load = 1'b1;
        run_exec_only(16'h0126, s, "ret_cmp");
        s = '0; s.rf_write = 1'b1; s.regw_sel = 2'd2;
        run_exec_only(16'h5A17, s, "ret_ldi");
        run_branch(16'h040C, 1'b1, 1'b0, 1'b0, 2'd1, "ret_bnz");
`ifdef CU_RETIRE_CNT_EN
        check("ret.count", retired, 32'd4);
`endif

        instruct = 16'h000F;
        push_front_end(1'b1);
        push(EXEC, '0);
        for (int i = 0; i < 100; i++) push(HALT, '0, 1'b1);
        drain("halt");
        check("halt.hold", 32'(state_dbg), 32'(HALT));
        reset = 1'b1;
        #1;
        check("halt_rst.state",  32'(state_dbg), 32'(FETCH_A));
        check("halt_rst.halted", 32'(halted),    32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("halt_rel.state", 32'(state_dbg), 32'(FETCH_B));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
